// File: rtl/br_lite_injector.sv
// BrLite local-port injector: turns PE service requests into br_data_t packets and
// follows every ALL/TGT packet with a delayed CLEAR carrying the same id.
module br_lite_injector #(
    parameter logic [15:0] ADDRESS     = 16'h0000,
    parameter int unsigned CLEAR_DELAY = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    input  logic [1:0]  src_service_i,
    input  logic [15:0] src_target_i,
    input  logic [7:0]  src_ksvc_i,
    input  logic [31:0] src_payload_i,
    output logic [4:0]  src_id_o,
    output logic        src_err_o,
    output logic        br_req_o,
    input  logic        br_ack_i,
    output logic [94:0] br_data_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_MON   = 2'd2,
        BR_SVC_CLEAR = 2'd3
    } br_svc_t;

    typedef struct packed {
        logic [31:0] payload;
        logic [15:0] seq_target;
        logic [15:0] seq_source;
        logic [15:0] producer;
        logic [7:0]  ksvc;
        logic [4:0]  id;
        br_svc_t     service;
    } br_data_t;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, CLEAR} state_t;

    // Counter preload; guarded so CLEAR_DELAY=0 never computes an underflowed constant.
    localparam logic [15:0] WAIT_LOAD = (CLEAR_DELAY == 0) ? 16'd0 : 16'(CLEAR_DELAY - 1);

    state_t      state_q, state_d;
    br_data_t    pkt_q, pkt_d;
    logic [4:0]  id_q, id_d;
    logic [15:0] cnt_q, cnt_d;
    logic        src_xfer, br_xfer;
    br_svc_t     req_svc;

    assign src_ready_o = (state_q == IDLE);
    assign br_req_o    = (state_q == SEND) || (state_q == CLEAR);
    assign busy_o      = (state_q != IDLE);
    assign src_id_o    = id_q;
    assign br_data_o   = pkt_q;

    assign src_xfer = src_valid_i & src_ready_o;
    assign br_xfer  = br_req_o & br_ack_i;
    assign req_svc  = br_svc_t'(src_service_i);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        pkt_d     = pkt_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        src_err_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (src_xfer) begin
                    if (req_svc == BR_SVC_CLEAR) begin
                        src_err_o = 1'b1;
                    end else begin
                        pkt_d.payload    = src_payload_i;
                        pkt_d.seq_target = src_target_i;
                        pkt_d.seq_source = ADDRESS;
                        pkt_d.producer   = ADDRESS;
                        pkt_d.ksvc       = src_ksvc_i;
                        pkt_d.id         = id_q;
                        pkt_d.service    = req_svc;
                        id_d             = id_q + 5'd1;
                        state_d          = SEND;
                    end
                end
            end
            SEND: begin
                if (br_xfer) begin
                    if (pkt_q.service == BR_SVC_MON) begin
                        state_d = IDLE;
                    end else begin
                        // The held packet becomes the CLEAR; all other fields stay intact.
                        pkt_d.service = BR_SVC_CLEAR;
                        if (CLEAR_DELAY == 0) begin
                            state_d = CLEAR;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = WAIT_LOAD;
                        end
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 16'd0) state_d = CLEAR;
                else                cnt_d   = cnt_q - 16'd1;
            end
            CLEAR: begin
                if (br_xfer) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the packet register is reset too, so br_data_o reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            id_q    <= 5'd0;
            cnt_q   <= 16'd0;
        end else begin
            // NOTE: non-blocking updates so all state samples the same pre-edge values.
            state_q <= state_d;
            pkt_q   <= pkt_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_br_lite_injector.sv
// Directed bench for br_lite_injector: one instance with CLEAR_DELAY=16, one with CLEAR_DELAY=0.
module tb_br_lite_injector;

    localparam logic [1:0]  SVC_ALL = 2'd0, SVC_TGT = 2'd1, SVC_MON = 2'd2, SVC_CLR = 2'd3;
    localparam logic [15:0] ADDR_A = 16'h0A05;
    localparam logic [15:0] ADDR_B = 16'h0102;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 0, a_ack = 0;
    logic [1:0]  a_service = 0;
    logic [15:0] a_target = 0;
    logic [7:0]  a_ksvc = 0;
    logic [31:0] a_payload = 0;
    logic        a_ready, a_err, a_req, a_busy;
    logic [4:0]  a_id;
    logic [94:0] a_data;

    logic        b_valid = 0, b_ack = 0;
    logic [1:0]  b_service = 0;
    logic [15:0] b_target = 0;
    logic [7:0]  b_ksvc = 0;
    logic [31:0] b_payload = 0;
    logic        b_ready, b_err, b_req, b_busy;
    logic [4:0]  b_id;
    logic [94:0] b_data;

    int total = 0;
    int bad   = 0;

    br_lite_injector #(.ADDRESS(ADDR_A), .CLEAR_DELAY(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .src_valid_i(a_valid), .src_ready_o(a_ready), .src_service_i(a_service),
        .src_target_i(a_target), .src_ksvc_i(a_ksvc), .src_payload_i(a_payload),
        .src_id_o(a_id), .src_err_o(a_err),
        .br_req_o(a_req), .br_ack_i(a_ack), .br_data_o(a_data), .busy_o(a_busy)
    );

    br_lite_injector #(.ADDRESS(ADDR_B), .CLEAR_DELAY(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .src_valid_i(b_valid), .src_ready_o(b_ready), .src_service_i(b_service),
        .src_target_i(b_target), .src_ksvc_i(b_ksvc), .src_payload_i(b_payload),
        .src_id_o(b_id), .src_err_o(b_err),
        .br_req_o(b_req), .br_ack_i(b_ack), .br_data_o(b_data), .busy_o(b_busy)
    );

    // Field order: payload, seq_target, seq_source, producer, ksvc, id, service.
    function automatic logic [94:0] mk(input logic [31:0] payload, input logic [15:0] target,
                                       input logic [15:0] addr, input logic [7:0] ksvc,
                                       input logic [4:0] id, input logic [1:0] svc);
        return {payload, target, addr, addr, ksvc, id, svc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({a_ready, a_err, a_req, a_busy} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1000", {a_ready, a_err, a_req, a_busy});
        end
        total++;
        if (a_id !== 5'd0 || a_data !== 95'd0) begin
            bad++;
            $display("FAIL reset_id_data: got id=%0d data=%h want id=0 data=0", a_id, a_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mon();
        logic [94:0] exp;
        int seen;
        tick();
        a_valid = 1; a_service = SVC_MON; a_payload = 32'hCAFE0001;
        a_target = 16'h1111; a_ksvc = 8'h22; a_ack = 1;
        #1;
        total++;
        if ({a_ready, a_id} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL mon_accept: got ready=%b id=%0d want ready=1 id=0", a_ready, a_id);
        end
        tick();
        a_valid = 0;
        #1;
        exp = mk(32'hCAFE0001, 16'h1111, ADDR_A, 8'h22, 5'd0, SVC_MON);
        total++;
        if (a_req !== 1'b1 || a_data !== exp) begin
            bad++;
            $display("FAIL mon_packet: got req=%b data=%h want req=1 data=%h", a_req, a_data, exp);
        end
        tick();
        #1;
        total++;
        if ({a_req, a_ready, a_busy} !== 3'b010) begin
            bad++;
            $display("FAIL mon_idle: got req/ready/busy=%b want 010", {a_req, a_ready, a_busy});
        end
        seen = 0;
        repeat (20) begin
            tick();
            if (a_req !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mon_no_clear: got %0d req cycles want 0", seen);
        end
        a_ack = 0;
    endtask

    task automatic test_all_hold();
        logic [94:0] exp;
        int stable_bad;
        int low;
        tick();
        a_valid = 1; a_service = SVC_ALL; a_payload = 32'hA11A0002;
        a_target = 16'h3344; a_ksvc = 8'h55; a_ack = 0;
        #1;
        total++;
        if (a_id !== 5'd1) begin
            bad++;
            $display("FAIL all_id: got %0d want 1", a_id);
        end
        tick();
        a_valid = 0;
        #1;
        exp = mk(32'hA11A0002, 16'h3344, ADDR_A, 8'h55, 5'd1, SVC_ALL);
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_req !== 1'b1 || a_data !== exp) stable_bad++;
            tick();
            #1;
        end
        total++;
        if (stable_bad != 0 || a_req !== 1'b1 || a_data !== exp) begin
            bad++;
            $display("FAIL all_hold: got %0d unstable cycles, req=%b data=%h want 0, req=1 data=%h",
                     stable_bad, a_req, a_data, exp);
        end
        a_ack = 1;
        tick();
        a_ack = 0;
        #1;
        low = 0;
        while (a_req === 1'b0 && low < 40) begin
            low++;
            tick();
            #1;
        end
        total++;
        if (low != 16) begin
            bad++;
            $display("FAIL all_gap: got %0d low cycles want 16", low);
        end
        exp = mk(32'hA11A0002, 16'h3344, ADDR_A, 8'h55, 5'd1, SVC_CLR);
        total++;
        if (a_req !== 1'b1 || a_data !== exp) begin
            bad++;
            $display("FAIL all_clear_pkt: got req=%b data=%h want req=1 data=%h", a_req, a_data, exp);
        end
        a_ack = 1;
        tick();
        a_ack = 0;
        #1;
        total++;
        if ({a_req, a_ready} !== 2'b01) begin
            bad++;
            $display("FAIL all_done: got req/ready=%b want 01", {a_req, a_ready});
        end
    endtask

    task automatic test_clear_delay0();
        logic [94:0] exp;
        tick();
        b_valid = 1; b_service = SVC_TGT; b_target = 16'h0203;
        b_payload = 32'h0000_7777; b_ksvc = 8'h11; b_ack = 1;
        #1;
        total++;
        if (b_id !== 5'd0) begin
            bad++;
            $display("FAIL tgt_id: got %0d want 0", b_id);
        end
        tick();
        b_valid = 0;
        #1;
        exp = mk(32'h0000_7777, 16'h0203, ADDR_B, 8'h11, 5'd0, SVC_TGT);
        total++;
        if (b_req !== 1'b1 || b_data !== exp) begin
            bad++;
            $display("FAIL tgt_packet: got req=%b data=%h want req=1 data=%h", b_req, b_data, exp);
        end
        tick();
        #1;
        exp = mk(32'h0000_7777, 16'h0203, ADDR_B, 8'h11, 5'd0, SVC_CLR);
        total++;
        if (b_req !== 1'b1 || b_data !== exp) begin
            bad++;
            $display("FAIL tgt_clear_next: got req=%b data=%h want req=1 data=%h", b_req, b_data, exp);
        end
        tick();
        #1;
        total++;
        if ({b_req, b_ready} !== 2'b01) begin
            bad++;
            $display("FAIL tgt_done: got req/ready=%b want 01", {b_req, b_ready});
        end
        b_ack = 0;
    endtask

    task automatic test_err();
        tick();
        a_valid = 1; a_service = SVC_CLR; a_payload = 32'h0E0E0E0E;
        #1;
        total++;
        if (a_err !== 1'b1) begin
            bad++;
            $display("FAIL err_pulse: got %b want 1", a_err);
        end
        tick();
        a_valid = 0;
        #1;
        total++;
        if ({a_err, a_req, a_ready} !== 3'b001) begin
            bad++;
            $display("FAIL err_after: got err/req/ready=%b want 001", {a_err, a_req, a_ready});
        end
        tick();
        a_valid = 1; a_service = SVC_MON; a_payload = 32'h0000_0042; a_ack = 1;
        #1;
        total++;
        if (a_id !== 5'd2) begin
            bad++;
            $display("FAIL err_id_kept: got %0d want 2", a_id);
        end
        tick();
        a_valid = 0;
        tick();
        a_ack = 0;
    endtask

    task automatic test_back_to_back();
        int id_bad;
        rst_n = 0;
        tick();
        rst_n = 1;
        a_ack = 1;
        id_bad = 0;
        for (int k = 0; k < 33; k++) begin
            tick();
            a_valid = 1; a_service = SVC_MON; a_payload = 32'(k);
            #1;
            if ({a_ready, a_id} !== {1'b1, 5'(k % 32)}) begin
                id_bad++;
                $display("FAIL b2b_src_id: k=%0d got ready=%b id=%0d want ready=1 id=%0d",
                         k, a_ready, a_id, k % 32);
            end
            tick();
            a_valid = 0;
            #1;
            if (a_req !== 1'b1 || a_data[6:2] !== 5'(k % 32)) begin
                id_bad++;
                $display("FAIL b2b_pkt_id: k=%0d got req=%b id=%0d want req=1 id=%0d",
                         k, a_req, a_data[6:2], k % 32);
            end
        end
        total++;
        if (id_bad != 0) bad++;
        tick();
        a_ack = 0;
    endtask

    task automatic test_reset_mid();
        int seen;
        tick();
        a_valid = 1; a_service = SVC_ALL; a_payload = 32'hBEEF0003; a_ack = 1;
        tick();
        a_valid = 0;
        tick();
        a_ack = 0;
        tick();
        tick();
        total++;
        if ({a_busy, a_req} !== 2'b10) begin
            bad++;
            $display("FAIL mid_in_wait: got busy/req=%b want 10", {a_busy, a_req});
        end
        rst_n = 0;
        #1;
        total++;
        if ({a_req, a_busy, a_ready, a_err} !== 4'b0010 || a_id !== 5'd0 || a_data !== 95'd0) begin
            bad++;
            $display("FAIL mid_wait_reset: got flags=%b id=%0d data=%h want 0010 id=0 data=0",
                     {a_req, a_busy, a_ready, a_err}, a_id, a_data);
        end
        tick();
        rst_n = 1;
        seen = 0;
        repeat (30) begin
            tick();
            if (a_req !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_wait_no_clear: got %0d req cycles want 0", seen);
        end

        a_valid = 1; a_service = SVC_ALL; a_payload = 32'hBEEF0004; a_ack = 0;
        #1;
        total++;
        if (a_id !== 5'd0) begin
            bad++;
            $display("FAIL mid_id_reset: got %0d want 0", a_id);
        end
        tick();
        a_valid = 0;
        #1;
        total++;
        if (a_req !== 1'b1) begin
            bad++;
            $display("FAIL mid_in_send: got req=%b want 1", a_req);
        end
        rst_n = 0;
        #1;
        total++;
        if ({a_req, a_busy, a_ready} !== 3'b001 || a_data !== 95'd0) begin
            bad++;
            $display("FAIL mid_send_reset: got req/busy/ready=%b data=%h want 001 data=0",
                     {a_req, a_busy, a_ready}, a_data);
        end
        tick();
        rst_n = 1;
        seen = 0;
        repeat (30) begin
            tick();
            if (a_req !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_send_no_clear: got %0d req cycles want 0", seen);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mon();
        test_all_hold();
        test_clear_delay0();
        test_err();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
